// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Shares the single-ported system RAM between the instruction
//             fetch path and the data memory path. One requester is granted
//             at a time. Grants alternate under contention. Each completion
//             is followed by one IDLE cycle.
//  Options  : define ARB_TIMEOUT_EN to enable the grant watchdog. The
//             watchdog aborts a grant that has waited TIMEOUT cycles.
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] DEADWORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  // instruction side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // data side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  // status
  output logic        arb_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  localparam logic [1:0] C_RAM_ACCESS = 2'd2;
  localparam logic [1:0] C_RAM_ERROR  = 2'd3;
  localparam logic       C_SRV_INSTR  = 1'b0;
  localparam logic       C_SRV_DATA   = 1'b1;

  state_t state_q;
  logic   last_srv_q;

  logic w_dreq;
  logic w_ram_done;
  logic w_i_active;
  logic w_d_active;
  logic w_timeout;
  logic w_i_done;
  logic w_d_done;

  assign w_dreq     = dREN | dWEN;
  assign w_ram_done = (ramstate == C_RAM_ACCESS) || (ramstate == C_RAM_ERROR);
  // "active" means granted and the owner still holds its request.
  // A dropped request in a grant state is an abort, so enables are zero.
  assign w_i_active = (state_q == IGNT) && iREN;
  assign w_d_active = (state_q == DGNT) && w_dreq;
  assign w_i_done   = w_i_active && (w_ram_done || w_timeout);
  assign w_d_done   = w_d_active && (w_ram_done || w_timeout);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // A granted transfer is aborted once it has waited TIMEOUT cycles without the RAM finishing.
  assign w_timeout = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT));

  // The watchdog counts granted cycles without completion.
  // Every grant is entered from IDLE, so clearing in IDLE clears on grant entry.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (!w_ram_done) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = 32'(TIMEOUT);
  assign w_timeout        = 1'b0;
`endif

  // Grant FSM. When both sides request in IDLE, the side not served last wins.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      last_srv_q <= C_SRV_INSTR;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_dreq && (!iREN || (last_srv_q == C_SRV_INSTR))) begin
            state_q <= DGNT;
          end else if (iREN) begin
            state_q <= IGNT;
          end
        end
        IGNT: begin
          if (!iREN) begin
            state_q <= IDLE;
          end else if (w_i_done) begin
            state_q    <= IDLE;
            last_srv_q <= C_SRV_INSTR;
          end
        end
        DGNT: begin
          if (!w_dreq) begin
            state_q <= IDLE;
          end else if (w_d_done) begin
            state_q    <= IDLE;
            last_srv_q <= C_SRV_DATA;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM steering. A write takes precedence over a read when both data enables are high.
  assign ramREN   = w_i_active || (w_d_active && !dWEN);
  assign ramWEN   = w_d_active && dWEN;
  assign ramaddr  = w_i_active ? iaddr : (w_d_active ? daddr : 32'd0);
  assign ramstore = w_d_active ? dstore : 32'd0;

  // The requester's wait signal drops in the cycle its grant completes.
  // It also drops whenever the requester is not requesting.
  assign iwait = iREN   && !w_i_done;
  assign dwait = w_dreq && !w_d_done;

  assign iload = (state_q == IGNT) ? (w_timeout ? DEADWORD : ramload) : 32'd0;
  assign dload = (state_q == DGNT) ? (w_timeout ? DEADWORD : ramload) : 32'd0;

  // One-cycle error flag when a RAM error or a watchdog abort ends an active grant.
  assign arb_err = (w_i_active || w_d_active) &&
                   ((ramstate == C_RAM_ERROR) || w_timeout);

endmodule
`default_nettype wire
